sobel_ctrl: RTL and testbench

Frame sequencer for the Sobel edge-detection top. On a start pulse it asserts the core-run level and streams one full frame of 8-bit pixels from frame memory into the Sobel datapath in raster order. It then waits for the datapath's done indication, counts the edge pixels emitted toward VGA, and reports frame completion to the system controller.

---
 rtl/sobel_ctrl_if.sv | 47 ++++
 rtl/sobel_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sobel_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_ctrl_if.sv
// -----------------------------------------------------------------------------
// sobel_ctrl_if
// Bundles the signals that connect the Sobel frame sequencer to its environment.
//   start      system controller -> sequencer, single-cycle frame start request
//   busy       sequencer -> system, high whenever the sequencer is not idle
//   done       sequencer -> system, one-cycle frame completion pulse
//   err        sequencer -> system, sticky frame-error flag
//   mem_rd     sequencer -> frame memory, read request
//   mem_addr   sequencer -> frame memory, read address (valid with mem_rd)
//   mem_gnt    frame memory -> sequencer, read accepted when mem_rd & mem_gnt
//   mem_data   frame memory -> sequencer, data one cycle after the accept
//   data       sequencer -> Sobel datapath, pixel value
//   data_en    sequencer -> Sobel datapath, pixel strobe
//   core_run   sequencer -> Sobel datapath, run level
//   core_done  Sobel datapath -> sequencer, datapath finished
//   pixel_en   Sobel datapath -> sequencer, output-pixel strobe (counted)
//   pix_cnt    sequencer -> system, output-pixel count of current/last frame
// Modports: master = the sequencer side, slave = the environment side.
// -----------------------------------------------------------------------------
interface sobel_ctrl_if #(
  parameter int ADDR_W = 19
);
  logic              start;
  logic              busy;
  logic              done;
  logic              err;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic [7:0]        mem_data;
  logic [7:0]        data;
  logic              data_en;
  logic              core_run;
  logic              core_done;
  logic              pixel_en;
  logic [ADDR_W-1:0] pix_cnt;

  modport master (
    input  start, mem_gnt, mem_data, core_done, pixel_en,
    output busy, done, err, mem_rd, mem_addr, data, data_en, core_run, pix_cnt
  );

  modport slave (
    output start, mem_gnt, mem_data, core_done, pixel_en,
    input  busy, done, err, mem_rd, mem_addr, data, data_en, core_run, pix_cnt
  );
endinterface

// File: rtl/sobel_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_ctrl
// Frame sequencer for the Sobel edge-detection top. A start request raises the
// core-run level and streams MAX_ROW*MAX_COL pixels from frame memory into the
// Sobel datapath in raster order. The sequencer then waits for the datapath to
// finish, counts the output pixels it reports and signals frame completion.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (synchronously released upstream)
//   bus    sobel_ctrl_if.master, see the interface file for the signal list
//
// Parameters: MAX_ROW, MAX_COL frame size; ADDR_W address/count width (must
// equal the interface ADDR_W and satisfy 2^ADDR_W >= MAX_ROW*MAX_COL);
// TIMEOUT_CYC watchdog limit in WAIT_CORE cycles.
//
// Build option: define SOBEL_CTRL_TIMEOUT_EN to build the WAIT_CORE watchdog.
// Without it WAIT_CORE waits indefinitely for core_done.
// -----------------------------------------------------------------------------
module sobel_ctrl #(
  parameter int MAX_ROW     = 540,
  parameter int MAX_COL     = 540,
  parameter int ADDR_W      = 19,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  sobel_ctrl_if.master bus
);

  localparam int                N         = MAX_ROW * MAX_COL;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] EXP_PIX   = ADDR_W'((MAX_ROW - 2) * (MAX_COL - 2));
  localparam logic [ADDR_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WAIT_CORE,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              rd_pend_reg;    // a read was accepted last cycle, data on mem_data now
  logic              last_pend_reg;  // ...and it was the read of the final address
  logic [7:0]        data_reg;
  logic              data_en_reg;
  logic              last_en_reg;    // current data_en strobe carries the final pixel
  logic              core_run_reg;
  logic              err_reg;
  logic [ADDR_W-1:0] pix_cnt_reg, pix_cnt_next;

  logic start_acc;
  logic rd_acc;
  logic timeout;

  assign start_acc = (state_reg == S_IDLE) && bus.start;
  assign rd_acc    = (state_reg == S_FETCH) && bus.mem_gnt;

`ifdef SOBEL_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_reg;

  // Held at zero outside WAIT_CORE, so it starts from zero on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_reg <= '0;
    end else if (state_reg != S_WAIT_CORE) begin
      wd_reg <= '0;
    end else begin
      wd_reg <= wd_reg + 1'b1;
    end
  end

  // Fires in the cycle whose closing edge brings the count to TIMEOUT_CYC.
  assign timeout = (state_reg == S_WAIT_CORE) && (wd_reg == WD_W'(TIMEOUT_CYC - 1));
`else
  // No watchdog: the comparison is constant false for any legal TIMEOUT_CYC.
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (bus.start) state_next = S_FETCH;
      S_FETCH:     if (rd_acc && (addr_reg == LAST_ADDR)) state_next = S_DRAIN;
      S_DRAIN:     if (data_en_reg && last_en_reg) state_next = S_WAIT_CORE;
      S_WAIT_CORE: if (bus.core_done || timeout) state_next = S_DONE;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Output-pixel counter: cleared on an accepted start, counts while busy, saturates.
  always_comb begin
    pix_cnt_next = pix_cnt_reg;
    if (start_acc) begin
      pix_cnt_next = '0;
    end else if ((state_reg != S_IDLE) && bus.pixel_en && (pix_cnt_reg != CNT_MAX)) begin
      pix_cnt_next = pix_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      rd_pend_reg   <= 1'b0;
      last_pend_reg <= 1'b0;
      data_reg      <= '0;
      data_en_reg   <= 1'b0;
      last_en_reg   <= 1'b0;
      core_run_reg  <= 1'b0;
      err_reg       <= 1'b0;
      pix_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;

      if (start_acc) begin
        addr_reg <= '0;
      end else if (rd_acc) begin
        addr_reg <= addr_reg + 1'b1;
      end

      // Two-stage return path: accept -> memory data -> registered strobe.
      rd_pend_reg   <= rd_acc;
      last_pend_reg <= rd_acc && (addr_reg == LAST_ADDR);
      data_en_reg   <= rd_pend_reg;
      last_en_reg   <= last_pend_reg;
      if (rd_pend_reg) begin
        data_reg <= bus.mem_data;
      end

      core_run_reg <= (state_next == S_FETCH) || (state_next == S_DRAIN) ||
                      (state_next == S_WAIT_CORE);

      pix_cnt_reg <= pix_cnt_next;

      // DONE is only entered from WAIT_CORE; the count check includes a
      // pixel strobe arriving in that same cycle.
      if (start_acc) begin
        err_reg <= 1'b0;
      end else if ((((state_reg == S_FETCH) || (state_reg == S_DRAIN)) && bus.core_done) ||
                   ((state_reg == S_WAIT_CORE) && (state_next == S_DONE) &&
                    ((pix_cnt_next != EXP_PIX) || timeout))) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign bus.busy     = (state_reg != S_IDLE);
  assign bus.done     = (state_reg == S_DONE);
  assign bus.err      = err_reg;
  assign bus.mem_rd   = (state_reg == S_FETCH);
  assign bus.mem_addr = addr_reg;
  assign bus.data     = data_reg;
  assign bus.data_en  = data_en_reg;
  assign bus.core_run = core_run_reg;
  assign bus.pix_cnt  = pix_cnt_reg;

endmodule

// File: tb/tb_sobel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sobel_ctrl
// Self-checking bench for sobel_ctrl on a 4x5 frame. A random-content frame
// memory answers reads one cycle after a grant; the reference model predicts
// the read address sequence, the pixel order/value and the strobe latency from
// the frame-sequencing rules, and each frame end is checked against the number
// of output pixels the bench injected (expected count (4-2)*(5-2) = 6).
// -----------------------------------------------------------------------------
module tb_sobel_ctrl;

  localparam int MAX_ROW     = 4;
  localparam int MAX_COL     = 5;
  localparam int ADDR_W      = 19;
  localparam int TIMEOUT_CYC = 16;
  localparam int N           = MAX_ROW * MAX_COL;
  localparam int E           = (MAX_ROW - 2) * (MAX_COL - 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  sobel_ctrl #(
    .MAX_ROW    (MAX_ROW),
    .MAX_COL    (MAX_COL),
    .ADDR_W     (ADDR_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0]        img [N];
  int                cyc = 0;
  int                rd_idx = 0;
  int                st_idx = 0;
  int                lat_q[$];
  bit                mon_en = 1'b0;
  bit                gnt_rand = 1'b0;
  bit                prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  int                last_st_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame memory: data for an accepted read is visible during the next cycle.
  always @(posedge clk) begin
    if (bus.mem_rd && bus.mem_gnt) bus.mem_data <= img[int'(bus.mem_addr) % N];
  end

  // Grant driver, changes just after each rising edge.
  initial begin
    bus.mem_gnt = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: reads must walk 0..N-1, stalls hold the address, and every
  // accept produces exactly one strobe two cycles later carrying img[addr].
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.mem_rd && prev_stall) check_eq("stall_hold", 32'(bus.mem_addr), 32'(prev_addr));
        if (bus.mem_rd && bus.mem_gnt) begin
          check_eq("rd_addr", 32'(bus.mem_addr), rd_idx);
          rd_idx++;
          lat_q.push_back(cyc + 2);
        end
        prev_stall = bus.mem_rd && !bus.mem_gnt;
        prev_addr  = bus.mem_addr;
        if (bus.data_en) begin
          if (lat_q.size() == 0) begin
            check_eq("spurious_en", 32'(bus.data_en), 0);
          end else begin
            check_eq("en_latency", cyc, lat_q.pop_front());
          end
          if (st_idx < N) check_eq("pix_data", 32'(bus.data), 32'(img[st_idx]));
          st_idx++;
          if (st_idx == N) last_st_cyc = cyc;
        end
      end
    end
  end

  task automatic clear_model();
    lat_q.delete();
    rd_idx     = 0;
    st_idx     = 0;
    prev_stall = 1'b0;
  endtask

  task automatic start_frame(input bit rnd);
    for (int i = 0; i < N; i++) img[i] = 8'($urandom);
    clear_model();
    gnt_rand = rnd;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("start_busy", 32'(bus.busy), 1);
    check_eq("start_core_run", 32'(bus.core_run), 1);
    check_eq("start_pix_cnt", 32'(bus.pix_cnt), 0);
    check_eq("start_err", 32'(bus.err), 0);
  endtask

  task automatic wait_strobes(input bit mid_start, input bit early_done);
    bit s1 = 1'b0;
    bit s2 = 1'b0;
    for (int c = 0; c < 300 && st_idx < N; c++) begin
      @(negedge clk);
      bus.start     = 1'b0;
      bus.core_done = 1'b0;
      if (mid_start && !s1 && rd_idx >= 7) begin
        bus.start = 1'b1;
        s1 = 1'b1;
      end
      if (early_done && !s2 && rd_idx >= 12) begin
        bus.core_done = 1'b1;
        s2 = 1'b1;
      end
    end
    @(negedge clk);
    bus.start     = 1'b0;
    bus.core_done = 1'b0;
    check_eq("n_strobes", st_idx, N);
    check_eq("inflight_left", lat_q.size(), 0);
    check_eq("wait_busy", 32'(bus.busy), 1);
    check_eq("wait_core_run", 32'(bus.core_run), 1);
  endtask

  task automatic end_frame(input int npix, input bit coincide_start, input bit exp_err);
    for (int i = 0; i < npix; i++) begin
      bus.pixel_en = 1'b1;
      @(negedge clk);
    end
    bus.pixel_en  = 1'b0;
    bus.core_done = 1'b1;
    @(negedge clk);
    bus.core_done = 1'b0;
    check_eq("done_pulse", 32'(bus.done), 1);
    check_eq("done_core_run", 32'(bus.core_run), 0);
    check_eq("done_pix_cnt", 32'(bus.pix_cnt), npix);
    check_eq("done_err", 32'(bus.err), 32'(exp_err));
    if (coincide_start) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("done_one_cycle", 32'(bus.done), 0);
    check_eq("idle_busy", 32'(bus.busy), 0);
    check_eq("idle_pix_cnt", 32'(bus.pix_cnt), npix);
    check_eq("idle_err", 32'(bus.err), 32'(exp_err));
    repeat (2) @(negedge clk);
    check_eq("no_restart", 32'({bus.busy, bus.mem_rd}), 0);
    bus.pixel_en = 1'b1;
    @(negedge clk);
    bus.pixel_en = 1'b0;
    @(negedge clk);
    check_eq("idle_pix_ignored", 32'(bus.pix_cnt), npix);
    $display("frame done: pix_cnt=%0d err=%0d", bus.pix_cnt, bus.err);
  endtask

  initial begin
    #400000;
    n_bad++;
    $display("FAIL global_timeout: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "time limit");
  end

  initial begin
    bus.start     = 1'b0;
    bus.core_done = 1'b0;
    bus.pixel_en  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ctrl", 32'({bus.busy, bus.done, bus.err, bus.mem_rd, bus.data_en, bus.core_run}), 0);
    check_eq("rst_addr", 32'(bus.mem_addr), 0);
    check_eq("rst_pix_cnt", 32'(bus.pix_cnt), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Full grant, exact pixel count
    start_frame(1'b0);
    wait_strobes(1'b0, 1'b0);
    end_frame(E, 1'b0, 1'b0);

    // Random grant, exact count
    start_frame(1'b1);
    wait_strobes(1'b0, 1'b0);
    end_frame(E, 1'b0, 1'b0);

    // Random grant, one pixel short -> error
    start_frame(1'b1);
    wait_strobes(1'b0, 1'b0);
    end_frame(E - 1, 1'b0, 1'b1);

    // Start during FETCH and coinciding with DONE are ignored
    start_frame(1'b1);
    wait_strobes(1'b1, 1'b0);
    end_frame(E, 1'b1, 1'b0);

    // core_done during FETCH flags an error but the frame completes normally
    start_frame(1'b0);
    wait_strobes(1'b0, 1'b1);
    end_frame(E, 1'b0, 1'b1);

    // Asynchronous reset mid-frame, then a clean frame
    start_frame(1'b1);
    for (int c = 0; c < 200 && rd_idx < 10; c++) @(negedge clk);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_ctrl", 32'({bus.busy, bus.done, bus.err, bus.mem_rd, bus.data_en, bus.core_run}), 0);
    check_eq("async_rst_addr", 32'(bus.mem_addr), 0);
    check_eq("async_rst_data", 32'(bus.data), 0);
    check_eq("async_rst_pix_cnt", 32'(bus.pix_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    mon_en = 1'b1;
    @(negedge clk);
    check_eq("post_rst_idle", 32'(bus.busy), 0);
    start_frame(1'b0);
    wait_strobes(1'b0, 1'b0);
    end_frame(E, 1'b0, 1'b0);

    // core_done never arrives
    start_frame(1'b1);
    wait_strobes(1'b0, 1'b0);
`ifdef SOBEL_CTRL_TIMEOUT_EN
    begin
      int dc = -1;
      for (int c = 0; c < 100 && dc < 0; c++) begin
        @(negedge clk);
        if (bus.done) dc = cyc;
      end
      // WAIT_CORE is entered the cycle after the last strobe; DONE TIMEOUT_CYC later.
      check_eq("wd_delay", dc - last_st_cyc, TIMEOUT_CYC + 1);
      check_eq("wd_err", 32'(bus.err), 1);
      @(negedge clk);
      check_eq("wd_idle", 32'(bus.busy), 0);
    end
`else
    begin
      bit seen_done = 1'b0;
      repeat (64) begin
        @(negedge clk);
        if (bus.done) seen_done = 1'b1;
      end
      check_eq("hang_busy", 32'(bus.busy), 1);
      check_eq("hang_no_done", 32'(seen_done), 0);
      end_frame(0, 1'b0, 1'b1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
